// File: rtl/blackjack_deal_controller.sv
// -----------------------------------------------------------------------------
// blackjack_deal_controller
//   Sequences one BlackJack round on top of a 1..10 random card source:
//   deals P,D,P,D, runs the player hit/stand turn, then the dealer draw rule,
//   and reports totals, card counts and the round result.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | after reset, waiting for start
//   DEAL_P1 | request first player card
//   DEAL_D1 | request first dealer card
//   DEAL_P2 | request second player card
//   DEAL_D2 | request second dealer card
//   PLAYER  | player hit/stand (auto-exit on 21 or bust)
//   DEALER  | dealer draws while effective < DEALER_STAND
//   DONE    | round finished, totals/result held
//
// Ports
//   clock_i          system clock
//   reset_i          synchronous active-high reset
//   start_i          begin round (IDLE/DONE only)
//   hit_i, stand_i   player controls (PLAYER only, ignored while card pending)
//   card_req_o       card request, held until a legal card is accepted
//   card_valid_i     card_in_i valid this cycle
//   card_in_i        card value 1..10 (1 = ace)
//   player_total_o   player effective total
//   dealer_total_o   dealer effective total
//   player_cards_o   player card count
//   dealer_cards_o   dealer card count
//   state_out_o      current state code
//   game_over_o      high in DONE
//   result_o         00 none, 01 player, 10 dealer, 11 push
// -----------------------------------------------------------------------------
module blackjack_deal_controller #(
    parameter int DEALER_STAND = 17,
    parameter int MAX_CARDS    = 5,
    parameter int BJ_LIMIT     = 21
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       hit_i,
    input  logic       stand_i,
    output logic       card_req_o,
    input  logic       card_valid_i,
    input  logic [4:0] card_in_i,
    output logic [4:0] player_total_o,
    output logic [4:0] dealer_total_o,
    output logic [2:0] player_cards_o,
    output logic [2:0] dealer_cards_o,
    output logic [2:0] state_out_o,
    output logic       game_over_o,
    output logic [1:0] result_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DEAL_P1 = 3'd1,
        S_DEAL_D1 = 3'd2,
        S_DEAL_P2 = 3'd3,
        S_DEAL_D2 = 3'd4,
        S_PLAYER  = 3'd5,
        S_DEALER  = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    localparam logic [4:0] STAND_5 = 5'(DEALER_STAND);
    localparam logic [4:0] LIMIT_5 = 5'(BJ_LIMIT);
    localparam logic [2:0] MAXC_3  = 3'(MAX_CARDS);

    state_t     state_q, state_d;
    logic [4:0] p_hard_q, p_hard_d, d_hard_q, d_hard_d;
    logic       p_ace_q, p_ace_d, d_ace_q, d_ace_d;
    logic [2:0] p_cnt_q, p_cnt_d, d_cnt_q, d_cnt_d;
    logic [1:0] result_q, result_d;
    // Pending draw during PLAYER/DEALER; deal states request unconditionally.
    logic       req_q, req_d;

    logic [4:0] p_eff, d_eff;
    logic       in_deal, card_legal, accept, to_player;

    // An ace counts 11 only when that keeps the hand at or below 21.
    function automatic logic [4:0] effective(input logic [4:0] hard, input logic ace);
        return (ace && hard <= 5'd11) ? hard + 5'd10 : hard;
    endfunction

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            p_hard_q <= '0;
            d_hard_q <= '0;
            p_ace_q  <= 1'b0;
            d_ace_q  <= 1'b0;
            p_cnt_q  <= '0;
            d_cnt_q  <= '0;
            result_q <= 2'b00;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_hard_q <= p_hard_d;
            d_hard_q <= d_hard_d;
            p_ace_q  <= p_ace_d;
            d_ace_q  <= d_ace_d;
            p_cnt_q  <= p_cnt_d;
            d_cnt_q  <= d_cnt_d;
            result_q <= result_d;
            req_q    <= req_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        p_hard_d = p_hard_q;
        d_hard_d = d_hard_q;
        p_ace_d  = p_ace_q;
        d_ace_d  = d_ace_q;
        p_cnt_d  = p_cnt_q;
        d_cnt_d  = d_cnt_q;
        result_d = result_q;
        req_d    = req_q;

        p_eff      = effective(p_hard_q, p_ace_q);
        d_eff      = effective(d_hard_q, d_ace_q);
        in_deal    = (state_q == S_DEAL_P1) || (state_q == S_DEAL_D1) ||
                     (state_q == S_DEAL_P2) || (state_q == S_DEAL_D2);
        card_req_o = in_deal || req_q;
        card_legal = card_valid_i && (card_in_i >= 5'd1) && (card_in_i <= 5'd10);
        accept     = card_req_o && card_legal;
        to_player  = (state_q == S_DEAL_P1) || (state_q == S_DEAL_P2) ||
                     (state_q == S_PLAYER);

        if (accept) begin
            req_d = 1'b0;
            if (to_player) begin
                p_hard_d = p_hard_q + card_in_i;
                p_ace_d  = p_ace_q | (card_in_i == 5'd1);
                p_cnt_d  = p_cnt_q + 3'd1;
            end else begin
                d_hard_d = d_hard_q + card_in_i;
                d_ace_d  = d_ace_q | (card_in_i == 5'd1);
                d_cnt_d  = d_cnt_q + 3'd1;
            end
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    p_hard_d = '0;
                    d_hard_d = '0;
                    p_ace_d  = 1'b0;
                    d_ace_d  = 1'b0;
                    p_cnt_d  = '0;
                    d_cnt_d  = '0;
                    result_d = 2'b00;
                    req_d    = 1'b0;
                    state_d  = S_DEAL_P1;
                end
            end
            S_DEAL_P1: if (accept) state_d = S_DEAL_D1;
            S_DEAL_D1: if (accept) state_d = S_DEAL_P2;
            S_DEAL_P2: if (accept) state_d = S_DEAL_D2;
            S_DEAL_D2: if (accept) state_d = S_PLAYER;
            S_PLAYER: begin
                // Hand is re-evaluated the cycle after each accepted card.
                if (!req_q) begin
                    if (p_hard_q > LIMIT_5) begin
                        state_d  = S_DONE;
                        result_d = 2'b10;
                    end else if (p_eff == LIMIT_5) begin
                        state_d = S_DEALER;
                    end else if (stand_i) begin
                        state_d = S_DEALER;
                    end else if (hit_i && (p_cnt_q < MAXC_3)) begin
                        req_d = 1'b1;
                    end
                end
            end
            S_DEALER: begin
                if (!req_q) begin
                    if ((d_eff < STAND_5) && (d_cnt_q < MAXC_3)) begin
                        req_d = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        if (d_hard_q > LIMIT_5)  result_d = 2'b01;
                        else if (p_eff > d_eff)  result_d = 2'b01;
                        else if (d_eff > p_eff)  result_d = 2'b10;
                        else                     result_d = 2'b11;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        player_total_o = p_eff;
        dealer_total_o = d_eff;
        player_cards_o = p_cnt_q;
        dealer_cards_o = d_cnt_q;
        state_out_o    = state_q;
        game_over_o    = (state_q == S_DONE);
        result_o       = result_q;
    end

endmodule
